clock_time_ctrl: RTL and testbench

Timekeeping and set-mode controller for the digital clock. It holds the seconds, minutes and hours binary counters and runs the RUN/SET_HOUR/SET_MIN mode FSM from debounced button pulses. It also time-shares one external binary-to-BCD splitter (1-cycle registered latency, input 0..59) between minutes and hours, and registers the returned digit pairs for the display driver.

---
 rtl/clock_time_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Digital-clock timekeeping core: sec/min/hour counters, RUN/SET mode FSM, blink,
// and time-sharing of one external BCD splitter between the minute and hour displays.
//
// state        | meaning
// ST_RUN       | clock runs from tick, btn_inc ignored
// ST_SET_HOUR  | counters frozen, btn_inc steps hours, hour digits blink
// ST_SET_MIN   | counters frozen, btn_inc steps minutes, minute digits blink
module clock_time_ctrl #(
    parameter int unsigned SEC_MAX  = 59,
    parameter int unsigned MIN_MAX  = 59,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] minute,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min,
    output logic [5:0] conv_val,
    input  logic [3:0] conv_dig0,
    input  logic [3:0] conv_dig1,
    output logic [3:0] min_d0,
    output logic [3:0] min_d1,
    output logic [3:0] hr_d0,
    output logic [3:0] hr_d1
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);

    mode_e      mode_q, mode_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic       blink_q, blink_d;
    logic       inc_ok;

    logic       phase_q;
    logic [5:0] conv_val_q;
    logic [1:0] tag_q;
    logic [1:0] valid_q;
    logic [3:0] min_d0_q, min_d1_q, hr_d0_q, hr_d1_q;

    always_ff @(posedge clk) begin
        if (reset_) begin
            mode_q <= ST_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (btn_mode) begin
            case (mode_q)
                ST_RUN:      mode_d = ST_SET_HOUR;
                ST_SET_HOUR: mode_d = ST_SET_MIN;
                default:     mode_d = ST_RUN;
            endcase
        end
    end

    // A mode press swallows a coincident increment.
    assign inc_ok = btn_inc & ~btn_mode & (mode_q != ST_RUN);

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        blink_d = blink_q;

        if ((mode_q == ST_RUN) && tick) begin
            if (sec_q == SEC_LAST) begin
                sec_d = '0;
                if (min_q == MIN_LAST) begin
                    min_d  = '0;
                    hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (inc_ok) begin
            if (mode_q == ST_SET_HOUR) begin
                hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + 5'd1;
            end else begin
                min_d = (min_q == MIN_LAST) ? '0 : min_q + 6'd1;
            end
        end

        // Entering SET_HOUR zeroes seconds even if a tick lands on the same edge.
        if (btn_mode && (mode_q == ST_RUN)) begin
            sec_d = '0;
        end

        if (btn_mode || inc_ok) begin
            blink_d = 1'b0;
        end else if (tick && (mode_q != ST_RUN)) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            blink_q <= blink_d;
        end
    end

    // Splitter sharing: phase 0 sends minutes, phase 1 sends hours; the tag rides
    // alongside for two edges so returning digits land in the right pair.
    always_ff @(posedge clk) begin
        if (reset_) begin
            phase_q    <= 1'b0;
            conv_val_q <= '0;
            tag_q      <= '0;
            valid_q    <= '0;
            min_d0_q   <= '0;
            min_d1_q   <= '0;
            hr_d0_q    <= '0;
            hr_d1_q    <= '0;
        end else begin
            phase_q    <= ~phase_q;
            conv_val_q <= phase_q ? {1'b0, hour_q} : min_q;
            tag_q      <= {tag_q[0], phase_q};
            valid_q    <= {valid_q[0], 1'b1};
            if (valid_q[1]) begin
                if (tag_q[1]) begin
                    hr_d0_q <= conv_dig0;
                    hr_d1_q <= conv_dig1;
                end else begin
                    min_d0_q <= conv_dig0;
                    min_d1_q <= conv_dig1;
                end
            end
        end
    end

    assign sec        = sec_q;
    assign minute     = min_q;
    assign hour       = hour_q;
    assign mode       = mode_q;
    assign blank_hour = (mode_q == ST_SET_HOUR) & blink_q;
    assign blank_min  = (mode_q == ST_SET_MIN) & blink_q;
    assign conv_val   = conv_val_q;
    assign min_d0     = min_d0_q;
    assign min_d1     = min_d1_q;
    assign hr_d0      = hr_d0_q;
    assign hr_d1      = hr_d1_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed scenarios plus random button/tick traffic,
// all compared every cycle against a time-of-day reference model and a splitter model.
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       reset_;
    logic       tick, btn_mode, btn_inc;
    logic [5:0] sec, minute, conv_val;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       blank_hour, blank_min;
    logic [3:0] conv_dig0 = '0, conv_dig1 = '0;
    logic [3:0] min_d0, min_d1, hr_d0, hr_d1;

    int n_tests = 0;
    int n_fail  = 0;

    clock_time_ctrl dut (
        .clk(clk), .reset_(reset_), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec(sec), .minute(minute), .hour(hour), .mode(mode),
        .blank_hour(blank_hour), .blank_min(blank_min), .conv_val(conv_val),
        .conv_dig0(conv_dig0), .conv_dig1(conv_dig1),
        .min_d0(min_d0), .min_d1(min_d1), .hr_d0(hr_d0), .hr_d1(hr_d1)
    );

    always #5 clk = ~clk;

    // External splitter: one registered stage
    always @(posedge clk) begin
        conv_dig0 <= 4'(conv_val % 6'd10);
        conv_dig1 <= 4'(conv_val / 6'd10);
    end

    // Reference model state
    int m_sec, m_min, m_hour, m_mode, m_blink;
    int m_conv, m_md0, m_md1, m_hd0, m_hd1;
    int m_edges;
    int sent_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit m, input bit i);
        int  secs_of_day;
        bit  inc_ok;
        int  v;
        if (r) begin
            m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_blink = 0;
            m_conv = 0; m_md0 = 0; m_md1 = 0; m_hd0 = 0; m_hd1 = 0;
            m_edges = 0;
            sent_q.delete();
            return;
        end
        m_edges++;
        // Odd edges since reset send minutes, even edges send hours; the digits of a
        // value sent two edges ago are captured now.
        if (sent_q.size() == 2) begin
            v = sent_q.pop_front();
            if (m_edges % 2 == 1) begin m_md0 = v % 10; m_md1 = v / 10; end
            else                  begin m_hd0 = v % 10; m_hd1 = v / 10; end
        end
        m_conv = (m_edges % 2 == 1) ? m_min : m_hour;
        sent_q.push_back(m_conv);

        inc_ok = i && !m && (m_mode != 0);
        if (m_mode == 0 && t) begin
            secs_of_day = (m_hour * 3600 + m_min * 60 + m_sec + 1) % 86400;
            m_hour = secs_of_day / 3600;
            m_min  = (secs_of_day / 60) % 60;
            m_sec  = secs_of_day % 60;
        end
        if (inc_ok) begin
            if (m_mode == 1) m_hour = (m_hour + 1) % 24;
            else             m_min  = (m_min + 1) % 60;
        end
        if (m) begin
            if (m_mode == 0) m_sec = 0;
            m_mode  = (m_mode + 1) % 3;
            m_blink = 0;
        end else if (inc_ok) begin
            m_blink = 0;
        end else if (t && m_mode != 0) begin
            m_blink = 1 - m_blink;
        end
    endtask

    task automatic check_all();
        chk("sec",        int'(sec),        m_sec);
        chk("minute",     int'(minute),     m_min);
        chk("hour",       int'(hour),       m_hour);
        chk("mode",       int'(mode),       m_mode);
        chk("blank_hour", int'(blank_hour), (m_mode == 1) ? m_blink : 0);
        chk("blank_min",  int'(blank_min),  (m_mode == 2) ? m_blink : 0);
        chk("conv_val",   int'(conv_val),   m_conv);
        chk("min_d0",     int'(min_d0),     m_md0);
        chk("min_d1",     int'(min_d1),     m_md1);
        chk("hr_d0",      int'(hr_d0),      m_hd0);
        chk("hr_d1",      int'(hr_d1),      m_hd1);
    endtask

    task automatic cycle(input bit r, input bit t, input bit m, input bit i);
        reset_ = r; tick = t; btn_mode = m; btn_inc = i;
        @(posedge clk);
        model_step(r, t, m, i);
        #1;
        check_all();
        reset_ = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        reset_ = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 1);
        chk("reset_mode", int'(mode), 0);
        chk("reset_sec", int'(sec), 0);

        // 60 ticks in RUN
        for (int k = 0; k < 60; k++) begin
            cycle(0, 1, 0, 0);
            chk("run_sec", int'(sec), (k + 1) % 60);
        end
        idle(4);
        chk("one_min", int'(minute), 1);
        chk("one_min_d0", int'(min_d0), 1);
        chk("one_min_d1", int'(min_d1), 0);

        // Preload 23:59 and run to 23:59:58
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 23; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 58; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 58; k++) cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("pre_wrap_hour", int'(hour), 23);
        chk("pre_wrap_sec", int'(sec), 59);
        cycle(0, 1, 0, 0);
        chk("wrap_hour", int'(hour), 0);
        chk("wrap_min", int'(minute), 0);
        chk("wrap_sec", int'(sec), 0);
        idle(4);
        chk("wrap_hr_d0", int'(hr_d0), 0);
        chk("wrap_hr_d1", int'(hr_d1), 0);
        chk("wrap_min_d1", int'(min_d1), 0);

        // Enter SET_HOUR with a coincident tick at sec=30
        for (int k = 0; k < 30; k++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        chk("set_hour_mode", int'(mode), 1);
        chk("set_hour_sec", int'(sec), 0);
        for (int k = 0; k < 24; k++) cycle(0, 0, 0, 1);
        chk("hour_wrap_back", int'(hour), 0);
        cycle(0, 1, 0, 0);
        chk("blink_on", int'(blank_hour), 1);
        cycle(0, 0, 0, 1);
        chk("blink_cleared", int'(blank_hour), 0);

        // Mode + inc together, then 61 minute increments
        cycle(0, 0, 1, 1);
        chk("set_min_mode", int'(mode), 2);
        chk("set_min_hour", int'(hour), 1);
        for (int k = 0; k < 61; k++) cycle(0, 0, 0, 1);
        chk("min_no_carry_hour", int'(hour), 1);

        // Reset in SET_MIN at minute 45
        for (int k = 0; k < 60 && m_min != 45; k++) cycle(0, 0, 0, 1);
        chk("min_45", int'(minute), 45);
        cycle(1, 0, 0, 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_conv", int'(conv_val), 0);
        idle(6);

        // 12:34 and watch the splitter alternate
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 12; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 34; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        idle(8);
        chk("d_min_d1", int'(min_d1), 3);
        chk("d_min_d0", int'(min_d0), 4);
        chk("d_hr_d1", int'(hr_d1), 1);
        chk("d_hr_d0", int'(hr_d0), 2);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            cycle($urandom_range(0, 399) == 0,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 25);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
